// File: rtl/traffic_light_param.sv
// Parametrised single-approach traffic light.
// Timed cycle LEFT -> GREEN -> YELLOW -> RED, with emergency preemption (ALLSTOP)
// that resumes the interrupted phase exactly, and a flashing-red mode.
// Outputs are a Moore decode of the registered state.
module traffic_light_param #(
   parameter int LEFT_CYCLES   = 5,
   parameter int GREEN_CYCLES  = 10,
   parameter int YELLOW_CYCLES = 3,
   parameter int RED_CYCLES    = 18,
   parameter int FLASH_HALF    = 4,
   parameter int CNT_W         = 5,
   parameter int START_PHASE   = 0
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       emergency,
   input  logic       flash_mode,
   output logic [3:0] out,
   output logic [2:0] phase,
   output logic       phase_last
);

   typedef enum logic [2:0] {
      S_LEFT    = 3'd0,
      S_GREEN   = 3'd1,
      S_YELLOW  = 3'd2,
      S_RED     = 3'd3,
      S_ALLSTOP = 3'd4,
      S_FLASH   = 3'd5
   } state_t;

   localparam state_t           START_S    = state_t'(START_PHASE[2:0]);
   localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

   // Final count value of a timed phase; non-timed states never use it.
   function automatic logic [CNT_W-1:0] last_cnt(input state_t s);
      case (s)
         S_LEFT:   return CNT_W'(LEFT_CYCLES - 1);
         S_GREEN:  return CNT_W'(GREEN_CYCLES - 1);
         S_YELLOW: return CNT_W'(YELLOW_CYCLES - 1);
         S_RED:    return CNT_W'(RED_CYCLES - 1);
         default:  return '0;
      endcase
   endfunction

   // Successor in the timed cycle; RED wraps back to LEFT.
   function automatic state_t next_timed(input state_t s);
      case (s)
         S_LEFT:   return S_GREEN;
         S_GREEN:  return S_YELLOW;
         S_YELLOW: return S_RED;
         default:  return S_LEFT;
      endcase
   endfunction

   state_t           state_q, state_d;
   state_t           saved_state_q, saved_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] saved_cnt_q, saved_cnt_d;
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_q, blink_d;
   logic             timed;
   logic             at_last;

   assign timed   = (state_q == S_LEFT) || (state_q == S_GREEN) ||
                    (state_q == S_YELLOW) || (state_q == S_RED);
   assign at_last = timed && (cnt_q == last_cnt(state_q));

   // State, phase counter, preemption context and blink generator registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= START_S;
         cnt_q         <= '0;
         saved_state_q <= START_S;
         saved_cnt_q   <= '0;
         blink_q       <= 1'b1;
         blink_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         saved_state_q <= saved_state_d;
         saved_cnt_q   <= saved_cnt_d;
         blink_q       <= blink_d;
         blink_cnt_q   <= blink_cnt_d;
      end
   end

   // Next-state logic: emergency beats flash mode, which beats normal timing.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      saved_state_d = saved_state_q;
      saved_cnt_d   = saved_cnt_q;
      blink_d       = blink_q;
      blink_cnt_d   = blink_cnt_q;

      if (emergency && (state_q != S_ALLSTOP)) begin
         state_d = S_ALLSTOP;
         cnt_d   = '0;
         // Remember where the timed cycle was interrupted; from FLASH or a
         // corrupt state the safe resume point is the start of RED.
         if (timed) begin
            saved_state_d = state_q;
            saved_cnt_d   = cnt_q;
         end else begin
            saved_state_d = S_RED;
            saved_cnt_d   = '0;
         end
      end else begin
         case (state_q)
            S_ALLSTOP: begin
               if (!emergency) begin
                  if (flash_mode) begin
                     state_d     = S_FLASH;
                     cnt_d       = '0;
                     blink_d     = 1'b1;
                     blink_cnt_d = '0;
                  end else begin
                     state_d = saved_state_q;
                     cnt_d   = saved_cnt_q;
                  end
               end
            end
            S_FLASH: begin
               if (!flash_mode) begin
                  state_d = S_RED;
                  cnt_d   = '0;
               end else if (blink_cnt_q == FLASH_LAST) begin
                  blink_cnt_d = '0;
                  blink_d     = ~blink_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + CNT_W'(1);
               end
            end
            S_LEFT, S_GREEN, S_YELLOW, S_RED: begin
               if (flash_mode) begin
                  state_d     = S_FLASH;
                  cnt_d       = '0;
                  blink_d     = 1'b1;
                  blink_cnt_d = '0;
               end else if (at_last) begin
                  state_d = next_timed(state_q);
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = S_RED;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Moore output decode of the registered state.
   always_comb begin
      out = 4'b0001;
      case (state_q)
         S_LEFT:    out = 4'b1001;
         S_GREEN:   out = 4'b0100;
         S_YELLOW:  out = 4'b0010;
         S_RED:     out = 4'b0001;
         S_ALLSTOP: out = 4'b0001;
         S_FLASH:   out = {3'b000, blink_q};
         default:   out = 4'b0001;
      endcase
   end

   assign phase      = state_q;
   assign phase_last = at_last;

endmodule

// File: tb/tb_traffic_light_param.sv
// Directed testbench for traffic_light_param: default-parameter instance for
// timing, preemption and flash scenarios, plus a START_PHASE=3 instance with
// 1-cycle phases for the mid-run reset scenario.
module tb_traffic_light_param;

   logic       clock;
   logic       reset_n;
   logic       reset_n1;
   logic       emergency;
   logic       flash_mode;
   logic [3:0] out;
   logic [2:0] phase;
   logic       phase_last;
   logic [3:0] out1;
   logic [2:0] phase1;
   logic       phase_last1;

   int checks = 0;
   int errors = 0;

   traffic_light_param u_dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .emergency  (emergency),
      .flash_mode (flash_mode),
      .out        (out),
      .phase      (phase),
      .phase_last (phase_last)
   );

   traffic_light_param #(
      .LEFT_CYCLES   (1),
      .GREEN_CYCLES  (1),
      .YELLOW_CYCLES (1),
      .RED_CYCLES    (1),
      .FLASH_HALF    (1),
      .CNT_W         (2),
      .START_PHASE   (3)
   ) u_dut1 (
      .clock      (clock),
      .reset_n    (reset_n1),
      .emergency  (1'b0),
      .flash_mode (1'b0),
      .out        (out1),
      .phase      (phase1),
      .phase_last (phase_last1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [3:0] dec(input int p);
      case (p)
         0:       return 4'b1001;
         1:       return 4'b0100;
         2:       return 4'b0010;
         default: return 4'b0001;
      endcase
   endfunction

   int dur[4] = '{5, 10, 3, 18};
   int ph;
   int cn;
   logic found;

   initial begin
      reset_n    = 1'b0;
      reset_n1   = 1'b0;
      emergency  = 1'b0;
      flash_mode = 1'b0;
      #12;
      check("rst_out", out, 4'b1001);
      check("rst_phase", phase, 0);
      check("rst_last", phase_last, 0);
      check("rst1_out", out1, 4'b0001);
      @(posedge clock);
      #1;
      reset_n  = 1'b1;
      reset_n1 = 1'b1;

      // Test 1: two full free-running cycles
      ph = 0;
      cn = 0;
      for (int i = 0; i < 72; i++) begin
         check("t1_phase", phase, ph);
         check("t1_out", out, dec(ph));
         check("t1_last", phase_last, (cn == dur[ph] - 1));
         tick();
         if (cn == dur[ph] - 1) begin
            ph = (ph + 1) % 4;
            cn = 0;
         end else begin
            cn++;
         end
      end
      check("t1_wrap", phase, 0);

      // Test 2: emergency for 3 cycles at GREEN cnt=4
      for (int i = 0; i < 9; i++) tick();
      check("t2_green", phase, 1);
      emergency = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_allstop_out", out, 4'b0001);
         check("t2_allstop_ph", phase, 4);
      end
      emergency = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t2_resume_ph", phase, 1);
         check("t2_resume_last", phase_last, (i == 5));
      end
      tick();
      check("t2_yellow", phase, 2);

      // Test 3: emergency on last YELLOW cycle
      tick();
      tick();
      check("t3_ylast", phase_last, 1);
      emergency = 1'b1;
      tick();
      check("t3_allstop", phase, 4);
      emergency = 1'b0;
      tick();
      check("t3_replay_ph", phase, 2);
      check("t3_replay_last", phase_last, 1);
      tick();
      check("t3_red_ph", phase, 3);
      check("t3_red_last", phase_last, 0);

      // Test 4: flash from RED, 1111 0000 1111, then full RED
      flash_mode = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("t4_flash_ph", phase, 5);
         check("t4_flash_out", out, ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0000);
      end
      flash_mode = 1'b0;
      for (int i = 0; i < 18; i++) begin
         tick();
         check("t4_red_ph", phase, 3);
         check("t4_red_last", phase_last, (i == 17));
      end
      tick();
      check("t4_left", phase, 0);

      // Test 5: emergency during FLASH, released with flash_mode still set
      flash_mode = 1'b1;
      tick();
      check("t5_flash", phase, 5);
      tick();
      emergency = 1'b1;
      tick();
      check("t5_allstop_ph", phase, 4);
      check("t5_allstop_out", out, 4'b0001);
      tick();
      check("t5_allstop_hold", phase, 4);
      emergency = 1'b0;
      tick();
      check("t5_reflash_ph", phase, 5);
      check("t5_reflash_out", out, 4'b0001);
      for (int i = 0; i < 3; i++) tick();
      check("t5_blink_on", out, 4'b0001);
      tick();
      check("t5_blink_off", out, 4'b0000);
      emergency = 1'b1;
      tick();
      check("t5_allstop2", phase, 4);
      emergency  = 1'b0;
      flash_mode = 1'b0;
      tick();
      check("t5_saved_red", phase, 3);
      check("t5_saved_cnt0", phase_last, 0);

      // Test 6: async reset mid-GREEN on the 1-cycle instance
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (phase1 == 3'd1) found = 1'b1;
         else tick();
      end
      check("t6_found_green", found, 1);
      reset_n1 = 1'b0;
      #2;
      check("t6_async_out", out1, 4'b0001);
      check("t6_async_ph", phase1, 3);
      reset_n1 = 1'b1;
      check("t6_red", phase1, 3);
      check("t6_red_last", phase_last1, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t6_seq_ph", phase1, (i + 4) % 4);
         check("t6_seq_out", out1, dec((i + 4) % 4));
         check("t6_seq_last", phase_last1, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
